vga_pixel_prefetch: RTL and testbench

//  Prefetch stage between the pixel source (image ROM/framebuffer) and vga_driver.

---
 rtl/vga_pkg.sv | 8 +
 rtl/vga_pixel_fifo_mem.sv | 19 +
 rtl/vga_pixel_prefetch.sv | 126 ++++++++++++
 tb/tb_vga_pixel_prefetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA widths and default active-frame geometry.
package vga_pkg;
    localparam int H_PIXELS_DEF = 640;
    localparam int V_LINES_DEF  = 480;
    localparam int RGB_W        = 3;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;
endpackage

// File: rtl/vga_pixel_fifo_mem.sv
// vga_pixel_fifo_mem: DEPTH x RGB_W storage, one synchronous write port, one asynchronous read port.
module vga_pixel_fifo_mem import vga_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [RGB_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [RGB_W-1:0] rdata_o
);
    logic [RGB_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/vga_pixel_prefetch.sv
// vga_pixel_prefetch: credit-based pixel prefetcher feeding vga_driver from a variable-latency source.
// Define VGA_PIXEL_PREFETCH_STATS_EN to add the underflow counter and minimum-level monitor.
module vga_pixel_prefetch import vga_pkg::*; #(
    parameter int               DEPTH         = 16,
    parameter int               H_PIXELS      = H_PIXELS_DEF,
    parameter int               V_LINES       = V_LINES_DEF,
    parameter logic [RGB_W-1:0] UNDERFLOW_RGB = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_frame_start,
    output logic                     o_src_req,
    output logic [X_W-1:0]           o_src_x,
    output logic [Y_W-1:0]           o_src_y,
    input  logic                     i_src_valid,
    input  logic [RGB_W-1:0]         i_src_rgb,
    input  logic                     i_fetch_next_pixel,
    output logic [RGB_W-1:0]         o_pixel_rgb,
    output logic                     o_underflow,
    output logic [$clog2(DEPTH):0]   o_level
`ifdef VGA_PIXEL_PREFETCH_STATS_EN
    ,
    output logic [15:0]              o_underflow_cnt,
    output logic [$clog2(DEPTH):0]   o_min_level
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    level_q, level_d, out_q, out_d, drop_q, drop_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             req_q, req_d, done_q, done_d, unf_q, unf_d;
    logic             v, push, pop;
    logic [RGB_W-1:0] head;

    vga_pixel_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (i_src_rgb),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // outstanding counts every request in flight, stale ones included, so credit bounds them too
    always_comb begin
        v        = i_src_valid && out_q != '0;
        push     = v && drop_q == '0 && !i_frame_start;
        pop      = i_fetch_next_pixel && level_q != '0 && !i_frame_start;
        unf_d    = i_fetch_next_pixel && level_q == '0 && !i_frame_start;
        out_d    = out_q + CW'(req_q) - CW'(v);
        drop_d   = i_frame_start ? out_d : drop_q - CW'(v && drop_q != '0);
        wr_ptr_d = i_frame_start ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = i_frame_start ? '0 : rd_ptr_q + AW'(pop);
        level_d  = i_frame_start ? '0 : level_q + CW'(push) - CW'(pop);
        x_d      = x_q;
        y_d      = y_q;
        done_d   = done_q;
        if (i_frame_start) begin
            x_d    = '0;
            y_d    = '0;
            done_d = 1'b0;
        end else if (req_q) begin
            x_d = (x_q == X_W'(H_PIXELS - 1)) ? '0 : x_q + 1'b1;
            if (x_q == X_W'(H_PIXELS - 1)) begin
                y_d    = (y_q == Y_W'(V_LINES - 1)) ? '0 : y_q + 1'b1;
                done_d = (y_q == Y_W'(V_LINES - 1));
            end
        end
        req_d = !i_frame_start && !done_d && ({1'b0, level_d} + {1'b0, out_d} < (CW + 1)'(DEPTH));
    end

    // frame_done comes out of reset set: nothing is fetched before the first frame_start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            req_q    <= 1'b0;
            done_q   <= 1'b1;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            x_q      <= x_d;
            y_q      <= y_d;
            req_q    <= req_d;
            done_q   <= done_d;
            unf_q    <= unf_d;
        end
    end

    assign o_src_req   = req_q;
    assign o_src_x     = x_q;
    assign o_src_y     = y_q;
    assign o_level     = level_q;
    assign o_underflow = unf_q;
    assign o_pixel_rgb = (level_q == '0) ? UNDERFLOW_RGB : head;

`ifdef VGA_PIXEL_PREFETCH_STATS_EN
    logic [15:0]   ucnt_q;
    logic [CW-1:0] min_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ucnt_q <= '0;
            min_q  <= CW'(DEPTH);
        end else begin
            if (unf_d && ucnt_q != '1) ucnt_q <= ucnt_q + 1'b1;
            min_q <= i_frame_start ? CW'(DEPTH) : (level_q < min_q ? level_q : min_q);
        end
    end

    assign o_underflow_cnt = ucnt_q;
    assign o_min_level     = min_q;
`endif
endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// tb_vga_pixel_prefetch: randomized bench against a queue-based model of requests, responses and FIFO.
module tb_vga_pixel_prefetch;
    localparam int DEPTH = 16, H = 20, V = 4, TOTAL = H * V;

    logic       clk = 1'b0, reset = 1'b1;
    logic       i_frame_start = 1'b0, i_src_valid = 1'b0, i_fetch_next_pixel = 1'b0;
    logic [2:0] i_src_rgb = '0;
    logic       o_src_req, o_underflow;
    logic [9:0] o_src_x;
    logic [8:0] o_src_y;
    logic [2:0] o_pixel_rgb;
    logic [4:0] o_level;
`ifdef VGA_PIXEL_PREFETCH_STATS_EN
    logic [15:0] o_underflow_cnt;
    logic [4:0]  o_min_level;
`endif

    always #20 clk = ~clk;

    vga_pixel_prefetch #(.DEPTH(DEPTH), .H_PIXELS(H), .V_LINES(V)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_frame_start      (i_frame_start),
        .o_src_req          (o_src_req),
        .o_src_x            (o_src_x),
        .o_src_y            (o_src_y),
        .i_src_valid        (i_src_valid),
        .i_src_rgb          (i_src_rgb),
        .i_fetch_next_pixel (i_fetch_next_pixel),
        .o_pixel_rgb        (o_pixel_rgb),
        .o_underflow        (o_underflow),
        .o_level            (o_level)
`ifdef VGA_PIXEL_PREFETCH_STATS_EN
        ,
        .o_underflow_cnt    (o_underflow_cnt),
        .o_min_level        (o_min_level)
`endif
    );

    typedef struct {
        int         due;
        logic [2:0] rgb;
        bit         stale;
    } req_t;

    req_t       infl[$];
    logic [2:0] fifo[$];
    int  checks = 0, errors = 0, cyc = 0, lat = 3, stall = 0;
    int  nreq = TOTAL, req_cnt = 0, unf_seen = 0, lx = -1, ly = -1, ucnt = 0, minl = DEPTH;
    bit  exp_req = 0, exp_unf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic check_all();
        chk("req", 32'(o_src_req), 32'(exp_req));
        if (exp_req) begin
            chk("x", 32'(o_src_x), nreq % H);
            chk("y", 32'(o_src_y), nreq / H);
        end
        chk("level", 32'(o_level), fifo.size());
        chk("rgb", 32'(o_pixel_rgb), fifo.size() > 0 ? 32'(fifo[0]) : 32'd0);
        chk("underflow", 32'(o_underflow), 32'(exp_unf));
`ifdef VGA_PIXEL_PREFETCH_STATS_EN
        chk("ucnt", 32'(o_underflow_cnt), ucnt);
        chk("min_level", 32'(o_min_level), minl);
`endif
    endtask

    // One clock: drive inputs, advance the model across the edge, then check at the next falling edge.
    task automatic tick(input bit fs, input bit fetch);
        bit   vld;
        int   pre;
        req_t e;
        if (o_src_req) begin
            lx = int'(o_src_x);
            ly = int'(o_src_y);
        end
        vld = infl.size() > 0 && infl[0].due <= cyc && $urandom_range(99) >= stall;
        i_frame_start      = fs;
        i_fetch_next_pixel = fetch;
        i_src_valid        = vld;
        i_src_rgb          = vld ? infl[0].rgb : 3'($urandom);
        pre = fifo.size();
        if (vld) begin
            e = infl.pop_front();
            if (!e.stale && !fs) fifo.push_back(e.rgb);
        end
        if (exp_req) begin
            infl.push_back('{due: cyc + lat, rgb: 3'($urandom), stale: 1'b0});
            nreq++;
            req_cnt++;
        end
        if (fs) begin
            fifo.delete();
            for (int i = 0; i < infl.size(); i++) infl[i].stale = 1'b1;
            nreq = 0; req_cnt = 0; exp_unf = 0; exp_req = 0;
            minl = DEPTH;
        end else begin
            exp_unf = fetch && pre == 0;
            if (fetch && pre > 0) void'(fifo.pop_front());
            exp_req = nreq < TOTAL && fifo.size() + infl.size() < DEPTH;
            if (pre < minl) minl = pre;
            if (exp_unf && ucnt < 65535) ucnt++;
        end
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_frame_start = 0; i_src_valid = 0; i_fetch_next_pixel = 0;
        fifo.delete(); infl.delete();
        nreq = TOTAL; exp_req = 0; exp_unf = 0; ucnt = 0; minl = DEPTH;
        @(negedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(o_src_req), 0);
        chk("rst_level", 32'(o_level), 0);
        chk("rst_rgb", 32'(o_pixel_rgb), 0);
        chk("rst_unf", 32'(o_underflow), 0);
        reset = 1'b0;

        lat = 3;
        tick(1, 0);
        repeat (30) tick(0, 0);
        chk("t1_reqs", req_cnt, 16);
        chk("t1_level", 32'(o_level), 16);
        chk("t1_req_off", 32'(o_src_req), 0);

        repeat (TOTAL) begin
            tick(0, 1);
            unf_seen += int'(o_underflow);
        end
        chk("t2_no_underflow", unf_seen, 0);
        repeat (10) tick(0, 0);
        chk("t2_last_x", lx, H - 1);
        chk("t2_last_y", ly, V - 1);
        chk("t2_done_req", 32'(o_src_req), 0);

        tick(1, 0);
        tick(0, 1);
        chk("t3_underflow", 32'(o_underflow), 1);
        chk("t3_rgb", 32'(o_pixel_rgb), 0);
        chk("t3_level", 32'(o_level), 0);
        repeat (20) tick(0, 0);

        lat = 20;
        tick(1, 0);
        for (int i = 0; i < 10 && infl.size() < 5; i++) tick(0, 0);
        tick(1, 0);
        lat = 3;
        repeat (60) tick(0, 0);
        chk("t4_level", 32'(o_level), 16);

        tick(1, 0);
        for (int i = 0; i < 40 && o_level < 5'd8; i++) tick(0, 0);
        chk("t5_pre_level", 32'(o_level), 8);
        tick(1, 1);
        chk("t5_no_underflow", 32'(o_underflow), 0);
        chk("t5_level", 32'(o_level), 0);
        chk("t5_x", 32'(o_src_x), 0);
        chk("t5_y", 32'(o_src_y), 0);

`ifdef VGA_PIXEL_PREFETCH_STATS_EN
        do_reset();
        tick(1, 0);
        repeat (3) tick(0, 1);
        chk("t6_ucnt", 32'(o_underflow_cnt), 3);
        chk("t6_min", 32'(o_min_level), 0);
        do_reset();
        chk("t6_ucnt_rst", 32'(o_underflow_cnt), 0);
`endif

        for (int blk = 0; blk < 6; blk++) begin
            int fetch_pct;
            fetch_pct = $urandom_range(30, 100);
            stall     = $urandom_range(0, 40);
            repeat (500) begin
                if ($urandom_range(599) == 0) do_reset();
                lat = $urandom_range(1, 6);
                tick($urandom_range(149) == 0, $urandom_range(99) < fetch_pct);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
